fetch_stage: RTL
================

// Module: fetch_stage
// PURPOSE
//  Instruction-fetch stage with IF/ID pipeline latch; sits directly downstream of the PC register.
//  Takes the current PC (imemaddr) and issues the I-cache read.
//  On ihit, captures the instruction and PC+4 into the IF/ID latch and returns pc_wen to advance the PC.
//  Handles hazard stalls, branch/jump flushes (including squash of an in-flight miss) and HALT detection.
// PARAMETERS
//  HALT_OP   6'h3F   opcode that stops fetch
//  NOP_WORD  32'h0   instruction word loaded into latch on flush/reset
// PORTS
//  clk        in   1   single clock, all state on posedge
//  nRst       in   1   reset: synchronous, active-high (1 = reset), sampled on posedge clk
//  imemaddr   in   32  current PC from PC register
//  ihit       in   1   I-cache hit/ready for current iaddr
//  iload      in   32  I-cache read data, valid when ihit
//  stall      in   1   hazard unit: hold IF/ID latch and PC
//  flush      in   1   branch/jump redirect: kill IF/ID contents
//  iREN       out  1   I-cache read enable
//  iaddr      out  32  I-cache address (= imemaddr)
//  pc_wen     out  1   PC write enable (combinational)
//  instr_out  out  32  IF/ID instruction
//  npc_out    out  32  IF/ID PC+4
//  valid_out  out  1   IF/ID entry valid
//  halt_out   out  1   HALT fetched; fetch stopped
//  fetch_cnt  out  32  [FETCH_PERF_EN only] instructions accepted
//  stall_cnt  out  32  [FETCH_PERF_EN only] cycles with stall=1 & valid_out=1
// BEHAVIOUR
//  Reset (nRst=1 at edge): state=FETCH; instr_out=NOP_WORD, npc_out=0, valid_out=0, halt_out=0.
//  Reset overrides flush/stall/ihit; reset mid-squash drops pending squash.
//  FSM states: FETCH, SQUASH, HALT (enum fetch_state_t).
//  iREN  = (state != HALT); iaddr = imemaddr always.
//  accept = (state==FETCH) & ihit & ~stall & ~flush; pc_wen = accept (same cycle, PC updates next edge).
//  accept: instr_out<=iload; npc_out<=imemaddr+32'd4 (mod 2^32, FFFF_FFFC -> 0000_0000); valid_out<=1.
//  accept with iload[31:26]==HALT_OP: latch as normal, state<=HALT, halt_out<=1.
//  FETCH & ~ihit & ~stall & ~flush: valid_out<=0 (bubble), instr_out<=NOP_WORD.
//  stall & ~flush: IF/ID latch held unchanged; pc_wen=0; ihit ignored (re-fetched after stall).
//  flush (priority over stall and ihit): valid_out<=0, instr_out<=NOP_WORD, pc_wen=0.
//   - FETCH & ihit=0: miss in flight -> state<=SQUASH.
//   - FETCH & ihit=1: data discarded, stay FETCH.
//   - HALT: HALT was speculative -> halt_out<=0, state<=FETCH.
//  SQUASH: iREN=1, pc_wen=0; first ihit discarded, state<=FETCH; further flush keeps SQUASH.
//  HALT: no fetch, pc_wen=0, latch held; only flush or reset leaves HALT.
//  Latency: ihit in cycle N -> instr_out/valid_out visible cycle N+1.
// CONFIGURATION
//  FETCH_PERF_EN defined: fetch_cnt (+1 per accept) and stall_cnt ports/registers present, reset to 0, wrap at 2^32.
//  FETCH_PERF_EN undefined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  cpu_types_pkg: word_t, opcode_t, fetch_state_t enum, HALT_OP and NOP_WORD constants.
//  Sub-module if_id_reg: IF/ID latch (instr/npc/valid) with enable (accept) and clear (flush/bubble).
//  fetch_stage keeps the FSM, accept logic and optional perf counters.
// TESTING
//  1 Reset: nRst=1 two cycles, ihit=1 -> iREN=1, pc_wen=0, valid_out=0, instr_out=0, halt_out=0.
//  2 Stream: imemaddr=0x40, iload=0x2021_0001, ihit=1 -> pc_wen=1; next cycle instr_out=0x2021_0001, npc_out=0x44, valid_out=1.
//  3 Stall: valid entry, stall=1 for 3 cycles with ihit=1 -> pc_wen=0, latch unchanged; stall_cnt +3 (PERF).
//  4 Squash: ihit=0, flush=1 -> SQUASH; next ihit=1 with 0xDEAD_BEEF -> discarded, valid_out=0; following ihit accepted.
//  5 Halt: iload=0xFC00_0000 accepted -> halt_out=1, iREN=0, pc_wen=0; flush=1 -> halt_out=0, fetch resumes.
//  6 Wrap: imemaddr=0xFFFF_FFFC accepted -> npc_out=0x0000_0000; flush+stall+ihit same cycle -> flush wins.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared types and constants for the fetch stage: word/opcode types, fetch FSM
// encoding, the HALT opcode and the NOP word loaded on flush/reset.
package cpu_types_pkg;

  typedef logic [31:0] word_t;
  typedef logic [5:0]  opcode_t;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    SQUASH = 2'd1,
    HALT   = 2'd2
  } fetch_state_t;

  localparam opcode_t HALT_OP_DEF  = 6'h3F;
  localparam word_t   NOP_WORD_DEF = 32'h0000_0000;

  function automatic opcode_t opcode_of(input word_t instr);
    return instr[31:26];
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline latch: instruction, PC+4 and valid bit.
// Priority: reset > clear > enable; otherwise the entry holds.
module if_id_reg
  import cpu_types_pkg::*;
#(
  parameter word_t NOP_WORD = NOP_WORD_DEF
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  en,
  input  logic  clr,
  input  word_t instr_i,
  input  word_t npc_i,
  output word_t instr_o,
  output word_t npc_o,
  output logic  valid_o
);

  word_t instr_q, instr_d;
  word_t npc_q, npc_d;
  logic  valid_q, valid_d;

  always_comb begin
    instr_d = instr_q;
    npc_d   = npc_q;
    valid_d = valid_q;
    if (clr) begin
      // npc is left as-is on a clear; only the valid bit gives it meaning
      instr_d = NOP_WORD;
      valid_d = 1'b0;
    end else if (en) begin
      instr_d = instr_i;
      npc_d   = npc_i;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q <= NOP_WORD;
      npc_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      npc_q   <= npc_d;
      valid_q <= valid_d;
    end
  end

  assign instr_o = instr_q;
  assign npc_o   = npc_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: FSM (FETCH/SQUASH/HALT), accept logic and IF/ID latch.
// Optional perf counters fetch_cnt/stall_cnt present when FETCH_PERF_EN is defined.
module fetch_stage
  import cpu_types_pkg::*;
#(
  parameter opcode_t HALT_OP  = HALT_OP_DEF,
  parameter word_t   NOP_WORD = NOP_WORD_DEF
) (
  input  logic        clk,
  input  logic        nRst,
  input  logic [31:0] imemaddr,
  input  logic        ihit,
  input  logic [31:0] iload,
  input  logic        stall,
  input  logic        flush,
  output logic        iREN,
  output logic [31:0] iaddr,
  output logic        pc_wen,
  output logic [31:0] instr_out,
  output logic [31:0] npc_out,
  output logic        valid_out,
  output logic        halt_out
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] fetch_cnt,
  output logic [31:0] stall_cnt
`endif
);

  // state  | meaning
  // FETCH  | normal fetch; accept on ihit when not stalled/flushed
  // SQUASH | a flushed miss is still in flight; discard its first ihit
  // HALT   | HALT opcode fetched; fetch stopped until flush or reset

  fetch_state_t state_q, state_d;
  logic accept;
  logic clr;

  assign accept = ~nRst & (state_q == FETCH) & ihit & ~stall & ~flush;
  assign pc_wen = accept;
  assign iREN   = (state_q != HALT);
  assign iaddr  = imemaddr;

  // Bubble on a plain miss, and drop whatever arrives while squashing
  assign clr = flush
             | ((state_q == FETCH)  & ~ihit & ~stall)
             | ((state_q == SQUASH) & ~stall);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FETCH: begin
        if (flush) begin
          if (!ihit) state_d = SQUASH;
        end else if (accept && opcode_of(iload) == HALT_OP) begin
          state_d = HALT;
        end
      end
      SQUASH: begin
        if (!flush && ihit) state_d = FETCH;
      end
      HALT: begin
        if (flush) state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (nRst) state_q <= FETCH;
    else      state_q <= state_d;
  end

  assign halt_out = (state_q == HALT);

  if_id_reg #(
    .NOP_WORD (NOP_WORD)
  ) u_if_id (
    .clk     (clk),
    .rst     (nRst),
    .en      (accept),
    .clr     (clr),
    .instr_i (iload),
    .npc_i   (imemaddr + 32'd4),
    .instr_o (instr_out),
    .npc_o   (npc_out),
    .valid_o (valid_out)
  );

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q + {31'd0, accept};
    stall_cnt_d = stall_cnt_q + {31'd0, stall & valid_out};
  end

  always_ff @(posedge clk) begin
    if (nRst) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign fetch_cnt = fetch_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule
